// File: rtl/model_tensor_stream_transmitter_if.sv
// Signal bundle for the tensor stream transmitter: buffer write port, size/start control,
// completion pulse and the i/j/k-tagged element stream.
interface model_tensor_stream_transmitter_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int MEMORY_DEPTH = 64,
    parameter int ADDRESS_SIZE = $clog2(MEMORY_DEPTH)
);
    logic                    start_i;
    logic                    ready_o;
    logic                    write_enable_i;
    logic [ADDRESS_SIZE-1:0] write_address_i;
    logic [DATA_SIZE-1:0]    write_data_i;
    logic [CONTROL_SIZE-1:0] size_i_i;
    logic [CONTROL_SIZE-1:0] size_j_i;
    logic [CONTROL_SIZE-1:0] size_k_i;
    logic                    data_out_i_enable_o;
    logic                    data_out_j_enable_o;
    logic                    data_out_k_enable_o;
    logic [DATA_SIZE-1:0]    data_out_o;

    modport master (
        output start_i, write_enable_i, write_address_i, write_data_i,
               size_i_i, size_j_i, size_k_i,
        input  ready_o, data_out_i_enable_o, data_out_j_enable_o,
               data_out_k_enable_o, data_out_o
    );

    modport slave (
        input  start_i, write_enable_i, write_address_i, write_data_i,
               size_i_i, size_j_i, size_k_i,
        output ready_o, data_out_i_enable_o, data_out_j_enable_o,
               data_out_k_enable_o, data_out_o
    );
endinterface

// File: rtl/model_tensor_stream_transmitter.sv
// Streams an i/j/k tensor out of a write-anytime element buffer, one registered element
// per cycle, tagging slice and row starts and pulsing ready when the tensor is done.
module model_tensor_stream_transmitter #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int MEMORY_DEPTH = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    model_tensor_stream_transmitter_if.slave bus
);
    localparam int ADDRESS_SIZE = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    typedef logic [CONTROL_SIZE-1:0] ctrl_t;
    typedef logic [ADDRESS_SIZE-1:0] addr_t;

    state_t               state_q, state_d;
    ctrl_t                size_i_q, size_i_d, size_j_q, size_j_d, size_k_q, size_k_d;
    ctrl_t                i_q, i_d, j_q, j_d, k_q, k_d;
    addr_t                addr_q, addr_d;
    logic                 ready_q, ready_d;
    logic                 i_en_q, i_en_d, j_en_q, j_en_d, k_en_q, k_en_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 emit;

    logic [DATA_SIZE-1:0] mem [MEMORY_DEPTH];

    // NOTE: the buffer is deliberately left out of reset so its contents survive rst and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (bus.write_enable_i) begin
            mem[bus.write_address_i] <= bus.write_data_i;
        end
    end

    function automatic addr_t next_addr(input addr_t a);
        return (a == addr_t'(MEMORY_DEPTH - 1)) ? '0 : a + addr_t'(1);
    endfunction

    // The first element is launched on the START edge itself, so data appears one cycle
    // after START; i reaching size_i marks "all emitted" and costs the extra cycle before DONE.
    always_comb begin
        // NOTE: every *_d gets its default before the case, so no path can infer a latch.
        state_d  = state_q;
        size_i_d = size_i_q;
        size_j_d = size_j_q;
        size_k_d = size_k_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ready_d  = 1'b0;
        i_en_d   = 1'b0;
        j_en_d   = 1'b0;
        k_en_d   = 1'b0;
        emit     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    size_i_d = bus.size_i_i;
                    size_j_d = bus.size_j_i;
                    size_k_d = bus.size_k_i;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    addr_d   = '0;
                    if (bus.size_i_i == '0 || bus.size_j_i == '0 || bus.size_k_i == '0) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = EMIT;
                        emit    = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (i_q == size_i_q) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (emit) begin
            data_d = mem[addr_d];
            k_en_d = 1'b1;
            j_en_d = (k_d == '0);
            i_en_d = (j_d == '0) && (k_d == '0);
            addr_d = next_addr(addr_d);
            if (k_d == size_k_d - ctrl_t'(1)) begin
                k_d = '0;
                if (j_d == size_j_d - ctrl_t'(1)) begin
                    j_d = '0;
                    i_d = i_d + ctrl_t'(1);
                end else begin
                    j_d = j_d + ctrl_t'(1);
                end
            end else begin
                k_d = k_d + ctrl_t'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            size_i_q <= '0;
            size_j_q <= '0;
            size_k_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            addr_q   <= '0;
            ready_q  <= 1'b0;
            i_en_q   <= 1'b0;
            j_en_q   <= 1'b0;
            k_en_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            size_i_q <= size_i_d;
            size_j_q <= size_j_d;
            size_k_q <= size_k_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            i_en_q   <= i_en_d;
            j_en_q   <= j_en_d;
            k_en_q   <= k_en_d;
            data_q   <= data_d;
        end
    end

    assign bus.ready_o             = ready_q;
    assign bus.data_out_i_enable_o = i_en_q;
    assign bus.data_out_j_enable_o = j_en_q;
    assign bus.data_out_k_enable_o = k_en_q;
    assign bus.data_out_o          = data_q;
endmodule

// File: tb/tb_model_tensor_stream_transmitter.sv
// Self-checking bench: a nested-loop tensor model predicts every emitted element, its i/j
// flags and the ready latency; table vectors, corner sequences and random runs drive it.
module tb_model_tensor_stream_transmitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    model_tensor_stream_transmitter_if #(.DATA_SIZE(64), .CONTROL_SIZE(64), .MEMORY_DEPTH(64)) bus ();
    model_tensor_stream_transmitter #(.DATA_SIZE(64), .CONTROL_SIZE(64), .MEMORY_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    model_tensor_stream_transmitter_if #(.DATA_SIZE(8), .CONTROL_SIZE(8), .MEMORY_DEPTH(4)) sbus ();
    model_tensor_stream_transmitter #(.DATA_SIZE(8), .CONTROL_SIZE(8), .MEMORY_DEPTH(4)) sdut (
        .clk(clk), .rst(rst), .bus(sbus)
    );

    typedef struct packed {
        logic        i_en;
        logic        j_en;
        logic [63:0] data;
    } elem_t;

    typedef struct {
        int si, sj, sk;
        int exp_elems;
        int exp_lat;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] shadow [64];
    elem_t       exp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_mem(input int addr, input logic [63:0] data);
        @(negedge clk);
        bus.write_enable_i  = 1'b1;
        bus.write_address_i = 6'(addr);
        bus.write_data_i    = data;
        @(negedge clk);
        bus.write_enable_i  = 1'b0;
        shadow[addr]        = data;
    endtask

    task automatic build_expected(input int si, input int sj, input int sk);
        exp_q.delete();
        for (int i = 0; i < si; i++)
            for (int j = 0; j < sj; j++)
                for (int k = 0; k < sk; k++)
                    exp_q.push_back('{i_en: (j == 0 && k == 0), j_en: (k == 0),
                                      data: shadow[((i * sj + j) * sk + k) % 64]});
    endtask

    // One transmission; hook_cycle > 0 re-pulses START with new sizes and writes
    // hook_addr during that cycle, while the model keeps its pre-write expectations.
    task automatic run_tx(input int si, input int sj, input int sk,
                          input int hook_cycle, input int hook_addr, input logic [63:0] hook_data,
                          output int n_elems, output int latency, output logic [63:0] last_data);
        int    budget;
        int    n_exp;
        elem_t e;
        build_expected(si, sj, sk);
        n_exp     = exp_q.size();
        budget    = n_exp + 10;
        n_elems   = 0;
        latency   = -1;
        last_data = '0;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.size_i_i = 64'(si);
        bus.size_j_i = 64'(sj);
        bus.size_k_i = 64'(sk);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            bus.start_i        = 1'b0;
            bus.write_enable_i = 1'b0;
            if (hook_cycle > 0 && c == hook_cycle + 1) shadow[hook_addr] = hook_data;
            if (bus.data_out_k_enable_o) begin
                n_elems++;
                if (exp_q.size() == 0) begin
                    check("extra_element", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("element", {bus.data_out_i_enable_o, bus.data_out_j_enable_o, bus.data_out_o}, e);
                    last_data = e.data;
                end
            end else if (bus.data_out_i_enable_o || bus.data_out_j_enable_o) begin
                check("stray_enable", {bus.data_out_i_enable_o, bus.data_out_j_enable_o}, 0);
            end
            if (bus.ready_o) begin
                latency = c;
                check("ready_enables_low",
                      {bus.data_out_i_enable_o, bus.data_out_j_enable_o, bus.data_out_k_enable_o}, 0);
                break;
            end
            if (c == hook_cycle) begin
                bus.start_i         = 1'b1;
                bus.size_i_i        = 64'd1;
                bus.size_j_i        = 64'd1;
                bus.size_k_i        = 64'd1;
                bus.write_enable_i  = 1'b1;
                bus.write_address_i = 6'(hook_addr);
                bus.write_data_i    = hook_data;
            end
        end
        if (latency < 0) check("ready_timeout", 0, 1);
        check("element_count", n_elems, n_exp);
        check("ready_latency", latency, n_exp + 1);
        if (n_exp > 0) check("data_hold", bus.data_out_o, last_data);
        @(negedge clk);
        check("ready_one_cycle", bus.ready_o, 0);
    endtask

    initial begin
        vec_t        tbl [8];
        int          n, lat, ready_at;
        logic [63:0] last;
        logic        seen_ready;
        int          exp38 [6];
        int          got38 [$];

        tbl[0] = '{2, 2, 2, 8, 9};
        tbl[1] = '{2, 0, 2, 0, 1};
        tbl[2] = '{0, 3, 3, 0, 1};
        tbl[3] = '{3, 1, 1, 3, 4};
        tbl[4] = '{1, 3, 2, 6, 7};
        tbl[5] = '{4, 4, 4, 64, 65};
        tbl[6] = '{1, 1, 5, 5, 6};
        tbl[7] = '{3, 3, 9, 81, 82};
        exp38  = '{10, 11, 12, 13, 10, 11};

        bus.start_i = 1'b0; bus.write_enable_i = 1'b0; bus.write_address_i = '0; bus.write_data_i = '0;
        bus.size_i_i = '0; bus.size_j_i = '0; bus.size_k_i = '0;
        sbus.start_i = 1'b0; sbus.write_enable_i = 1'b0; sbus.write_address_i = '0; sbus.write_data_i = '0;
        sbus.size_i_i = '0; sbus.size_j_i = '0; sbus.size_k_i = '0;
        for (int a = 0; a < 64; a++) shadow[a] = '0;

        #12;
        check("reset_outputs", {bus.ready_o, bus.data_out_i_enable_o, bus.data_out_j_enable_o,
                                bus.data_out_k_enable_o, bus.data_out_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 64; a++) write_mem(a, 64'(a + 1));

        // Basic 2x2x2 run: values 1..8, J on 1,3,5,7, I on 1,5, ready at cycle 9.
        run_tx(2, 2, 2, 0, 0, '0, n, lat, last);
        check("basic_last_value", last, 64'd8);

        // Reset in the middle of a run: outputs drop at once, no ready, then a clean replay.
        @(negedge clk);
        bus.start_i = 1'b1; bus.size_i_i = 64'd2; bus.size_j_i = 64'd2; bus.size_k_i = 64'd2;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_elem3", {bus.data_out_k_enable_o, bus.data_out_o}, {1'b1, 64'd3});
        #1 rst = 1'b1;
        #1;
        check("reset_immediate", {bus.ready_o, bus.data_out_i_enable_o, bus.data_out_j_enable_o,
                                  bus.data_out_k_enable_o, bus.data_out_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_ready = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.ready_o || bus.data_out_k_enable_o) seen_ready = 1'b1;
        end
        check("aborted_no_ready", seen_ready, 1'b0);
        run_tx(2, 2, 2, 0, 0, '0, n, lat, last);

        // START and sizes disturbed mid-run plus a same-cycle write to the address being read.
        run_tx(2, 2, 2, 3, 3, 64'h99, n, lat, last);
        check("disturbed_count", n, 8);
        run_tx(2, 2, 2, 0, 0, '0, n, lat, last);

        foreach (tbl[t]) begin
            run_tx(tbl[t].si, tbl[t].sj, tbl[t].sk, 0, 0, '0, n, lat, last);
            check("table_elements", n, tbl[t].exp_elems);
            check("table_latency", lat, tbl[t].exp_lat);
        end

        write_mem(0, 64'hA5);
        run_tx(1, 1, 1, 0, 0, '0, n, lat, last);
        check("single_value", last, 64'hA5);
        check("single_latency", lat, 2);

        for (int r = 0; r < 6; r++) begin
            repeat (8) write_mem($urandom_range(0, 63), {$urandom, $urandom});
            run_tx($urandom_range(0, 4), $urandom_range(1, 4), $urandom_range(1, 4), 0, 0, '0, n, lat, last);
        end

        // Four-deep buffer, 1x1x6: the linear address wraps after 3.
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            sbus.write_enable_i  = 1'b1;
            sbus.write_address_i = 2'(a);
            sbus.write_data_i    = 8'(10 + a);
        end
        @(negedge clk);
        sbus.write_enable_i = 1'b0;
        sbus.start_i = 1'b1; sbus.size_i_i = 8'd1; sbus.size_j_i = 8'd1; sbus.size_k_i = 8'd6;
        ready_at = -1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            sbus.start_i = 1'b0;
            if (sbus.data_out_k_enable_o) got38.push_back(int'(sbus.data_out_o));
            if (sbus.ready_o) begin
                ready_at = c;
                break;
            end
        end
        check("wrap_count", got38.size(), 6);
        for (int e = 0; e < 6; e++) begin
            if (e < got38.size()) check("wrap_value", got38[e], exp38[e]);
        end
        check("wrap_latency", ready_at, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
